// File: rtl/mc_control_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mc_control_pkg;

  // Controller states; numeric values are visible on state_o.
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_I_EXEC   = 4'd11,
    S_I_WB     = 4'd12,
    S_TRAP     = 4'd15
  } state_t;

  // Instruction class resolved from the opcode in DECODE.
  typedef enum logic [2:0] {
    CL_R, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_J, CL_I, CL_ILL
  } iclass_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  // R-type funct codes
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;

  // ALU control codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational ALU code / immediate-extension / legality decode.
module mc_alu_decode
  import mc_control_pkg::*;
#(
  parameter int OPW   = 6,
  parameter int ALUCW = 4
) (
  input  iclass_t          cls,
  input  logic [OPW-1:0]   opcode,
  input  logic [OPW-1:0]   funct,
  output logic [ALUCW-1:0] alu_ctrl,
  output logic             zero_ext,
  output logic             legal
);

  // Map class plus opcode/funct to the EXEC-stage ALU code.
  always_comb begin
    alu_ctrl = ALUCW'(ALU_ADD);
    zero_ext = 1'b0;
    legal    = 1'b1;
    case (cls)
      CL_R: begin
        case (funct)
          OPW'(F_ADD), OPW'(F_ADDU): alu_ctrl = ALUCW'(ALU_ADD);
          OPW'(F_SUB), OPW'(F_SUBU): alu_ctrl = ALUCW'(ALU_SUB);
          OPW'(F_AND):               alu_ctrl = ALUCW'(ALU_AND);
          OPW'(F_OR):                alu_ctrl = ALUCW'(ALU_OR);
          OPW'(F_NOR):               alu_ctrl = ALUCW'(ALU_NOR);
          OPW'(F_SLT):               alu_ctrl = ALUCW'(ALU_SLT);
          default:                   legal    = 1'b0;
        endcase
      end
      CL_I: begin
        case (opcode)
          OPW'(OP_ADDI): alu_ctrl = ALUCW'(ALU_ADD);
          OPW'(OP_ANDI): begin alu_ctrl = ALUCW'(ALU_AND); zero_ext = 1'b1; end
          OPW'(OP_ORI):  begin alu_ctrl = ALUCW'(ALU_OR);  zero_ext = 1'b1; end
          OPW'(OP_SLTI): alu_ctrl = ALUCW'(ALU_SLT);
          default:       legal    = 1'b0;
        endcase
      end
      CL_BEQ, CL_BNE: alu_ctrl = ALUCW'(ALU_SUB);
      CL_ILL:         legal    = 1'b0;
      default:        ;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM with memory wait timeout and illegal-op trap.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int OPW        = 6,
  parameter int ALUCW      = 4,
  parameter int WAIT_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPW-1:0]   opcode,
  input  logic [OPW-1:0]   funct,
  input  logic             mem_ready,
  input  logic             trap_clear,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic [ALUCW-1:0] alu_ctrl,
  output logic             zero_ext,
  output logic             illegal,
  output logic             bus_err,
  output logic [3:0]       state_o
);

  localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

  state_t           state, state_nx;
  iclass_t          cls, cls_r;
  logic [ALUCW-1:0] dec_ctrl, alu_ctrl_r;
  logic             dec_ze, dec_legal, ze_r;
  logic             illegal_r, bus_err_r;
  logic [CW-1:0]    wait_cnt, wait_nx;
  logic             waiting, timeout;

  // Opcode to instruction class.
  always_comb begin
    cls = CL_ILL;
    case (opcode)
      OPW'(OP_RTYPE): cls = CL_R;
      OPW'(OP_LW):    cls = CL_LW;
      OPW'(OP_SW):    cls = CL_SW;
      OPW'(OP_BEQ):   cls = CL_BEQ;
      OPW'(OP_BNE):   cls = CL_BNE;
      OPW'(OP_J):     cls = CL_J;
      OPW'(OP_ADDI), OPW'(OP_ANDI), OPW'(OP_ORI), OPW'(OP_SLTI): cls = CL_I;
      default:        cls = CL_ILL;
    endcase
  end

  mc_alu_decode #(
    .OPW   (OPW),
    .ALUCW (ALUCW)
  ) u_alu_decode (
    .cls      (cls),
    .opcode   (opcode),
    .funct    (funct),
    .alu_ctrl (dec_ctrl),
    .zero_ext (dec_ze),
    .legal    (dec_legal)
  );

  // Memory wait detection; mem_ready in the limit cycle takes priority.
  always_comb begin
    waiting = ((state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR)) && !mem_ready;
    timeout = waiting && (WAIT_LIMIT != 0) && (wait_cnt == CW'(WAIT_LIMIT));
    wait_nx = (waiting && !timeout && (WAIT_LIMIT != 0)) ? wait_cnt + CW'(1) : '0;
  end

  // State, wait counter, DECODE latches and sticky trap flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      cls_r      <= CL_R;
      alu_ctrl_r <= '0;
      ze_r       <= 1'b0;
      illegal_r  <= 1'b0;
      bus_err_r  <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      if (state == S_DECODE) begin
        cls_r      <= cls;
        alu_ctrl_r <= dec_ctrl;
        ze_r       <= dec_ze;
      end
      if ((state == S_TRAP) && trap_clear) begin
        illegal_r <= 1'b0;
        bus_err_r <= 1'b0;
      end else begin
        if ((state == S_DECODE) && !dec_legal) illegal_r <= 1'b1;
        if (timeout)                           bus_err_r <= 1'b1;
      end
    end
  end

  // Next-state and Moore control decode (FETCH IR/PC write gated by mem_ready).
  always_comb begin
    state_nx      = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    pc_source     = PCSRC_ALU;
    alu_ctrl      = '0;
    zero_ext      = 1'b0;
    case (state)
      S_IDLE: state_nx = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_ctrl  = ALUCW'(ALU_ADD);
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)    state_nx = S_DECODE;
        else if (timeout) state_nx = S_TRAP;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_ctrl  = ALUCW'(ALU_ADD);
        if (!dec_legal) state_nx = S_TRAP;
        else begin
          case (cls)
            CL_R:           state_nx = S_R_EXEC;
            CL_LW, CL_SW:   state_nx = S_MEM_ADDR;
            CL_BEQ, CL_BNE: state_nx = S_BRANCH;
            CL_J:           state_nx = S_JUMP;
            CL_I:           state_nx = S_I_EXEC;
            default:        state_nx = S_TRAP;
          endcase
        end
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = ALUCW'(ALU_ADD);
        state_nx  = (cls_r == CL_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready)    state_nx = S_MEM_WB;
        else if (timeout) state_nx = S_TRAP;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_nx   = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready)    state_nx = S_FETCH;
        else if (timeout) state_nx = S_TRAP;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = alu_ctrl_r;
        state_nx  = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_nx  = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = alu_ctrl_r;
        zero_ext  = ze_r;
        state_nx  = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        state_nx  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_ctrl      = ALUCW'(ALU_SUB);
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        branch_ne     = (cls_r == CL_BNE);
        state_nx      = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        state_nx  = S_FETCH;
      end
      S_TRAP: if (trap_clear) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign illegal = illegal_r;
  assign bus_err = bus_err_r;
  assign state_o = state;

endmodule
